pc_ir_unit: RTL

- Datapath-side sequential block that consumes the multicycle control FSM's register enables and PC select outputs.
- Holds the architectural PC, the instruction register (IR) and the non-architectural ALUOut and MDR registers.
- Computes the gated PC enable from the PCWrite/BEQ/BNE controls and the ALU Zero flag.
- Drives the Opcode field back to the control FSM, plus decoded instruction fields to the register file and extender.

---
 rtl/pc_ir_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pc_ir_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_ir_unit
// Purpose  : PC, instruction register, ALUOut and MDR datapath registers for
//            a multicycle MIPS core. Optional perf counters: PC_IR_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module pc_ir_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCWrite,
   input  logic             BEQ,
   input  logic             BNE,
   input  logic             IRWrite,
   input  logic [1:0]       PCSrc,
   input  logic             Zero,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic [WIDTH-1:0] MemRdData,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] Instr,
   output logic [5:0]       Opcode,
   output logic [5:0]       Funct,
   output logic [4:0]       Rs,
   output logic [4:0]       Rt,
   output logic [4:0]       Rd,
   output logic [WIDTH-1:0] SignImm,
   output logic [WIDTH-1:0] ALUOut,
   output logic [WIDTH-1:0] MDR,
   output logic             PCEn,
   output logic [1:0]       Fault,
   output logic [31:0]      InstrCount,
   output logic [31:0]      BranchCount
);

   localparam logic [1:0] c_src_alu      = 2'b00;
   localparam logic [1:0] c_src_aluout   = 2'b01;
   localparam logic [1:0] c_src_jump     = 2'b10;
   localparam logic [1:0] c_src_reserved = 2'b11;

   // MIPS field slicing below hard-codes 32-bit instruction positions.
   generate
      if (WIDTH != 32) begin : g_width_check
         $error("pc_ir_unit supports WIDTH == 32 only");
      end
   endgenerate

   logic [WIDTH-1:0] pc_reg;
   logic [WIDTH-1:0] ir_reg;
   logic [WIDTH-1:0] alu_out_reg;
   logic [WIDTH-1:0] mdr_reg;
   logic [1:0]       fault_reg;

   logic             conflict;
   logic             br_taken;
   logic             pc_en;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] jump_target;

   assign conflict    = BEQ & BNE;
   assign br_taken    = ~conflict & ((BEQ & Zero) | (BNE & ~Zero));
   assign pc_en       = (PCWrite | br_taken) & (PCSrc != c_src_reserved);
   assign jump_target = {pc_reg[WIDTH-1:WIDTH-4], ir_reg[25:0], 2'b00};

   always_comb begin
      pc_next = pc_reg;
      case (PCSrc)
         c_src_alu:    pc_next = ALUResult;
         c_src_aluout: pc_next = alu_out_reg;
         c_src_jump:   pc_next = jump_target;
         default:      pc_next = pc_reg;
      endcase
   end

   // PC write always forces word alignment; a misaligned source is flagged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg    <= RESET_PC;
         fault_reg <= 2'b00;
      end else begin
         if (pc_en) begin
            pc_reg <= {pc_next[WIDTH-1:2], 2'b00};
            if (pc_next[1:0] != 2'b00) begin
               fault_reg[0] <= 1'b1;
            end
         end
         if (conflict) begin
            fault_reg[1] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_reg      <= '0;
         alu_out_reg <= '0;
         mdr_reg     <= '0;
      end else begin
         if (IRWrite) begin
            ir_reg <= MemRdData;
         end
         alu_out_reg <= ALUResult;
         mdr_reg     <= MemRdData;
      end
   end

`ifdef PC_IR_PERF_CNT_EN
   logic [31:0] instr_cnt;
   logic [31:0] branch_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_cnt  <= '0;
         branch_cnt <= '0;
      end else begin
         if (IRWrite) begin
            instr_cnt <= instr_cnt + 32'd1;
         end
         if (br_taken & pc_en) begin
            branch_cnt <= branch_cnt + 32'd1;
         end
      end
   end

   assign InstrCount  = instr_cnt;
   assign BranchCount = branch_cnt;
`else
   assign InstrCount  = '0;
   assign BranchCount = '0;
`endif

   assign PC      = pc_reg;
   assign Instr   = ir_reg;
   assign ALUOut  = alu_out_reg;
   assign MDR     = mdr_reg;
   assign PCEn    = pc_en;
   assign Fault   = fault_reg;

   assign Opcode  = ir_reg[31:26];
   assign Rs      = ir_reg[25:21];
   assign Rt      = ir_reg[20:16];
   assign Rd      = ir_reg[15:11];
   assign Funct   = ir_reg[5:0];
   assign SignImm = {{(WIDTH-16){ir_reg[15]}}, ir_reg[15:0]};

endmodule
`default_nettype wire
